// File: rtl/alu_status_handler.sv
// alu_status_handler
//   Turns selected ALU status flags at the end of EX into precise exceptions.
//   Keeps the branch flags of the last committed instruction, latches the
//   trap cause / EPC / bad address, and runs a flush + stall handshake until
//   the exception controller acknowledges.
//
// Optional feature (macro ALU_EXC_COUNTER_EN):
//   defined   - exc_count counts IDLE->TRAP transitions, saturating at 2^CNT_W-1
//   undefined - exc_count is tied to 0, no counter flops
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   valid_in     EX holds a valid instruction
//   status_in    {zero, mul_ovf, carry, neg, addr_chk, div0, 2'b00}
//   result_in    ALU result / effective address
//   pc_in        PC of the EX instruction
//   chk_mask     per-instruction enables {carry, mul, align, div0}
//   exc_ack      exception controller has taken the trap
//   exc_req      exception pending
//   flush_out    one-cycle kill of IF/ID/EX
//   stall_out    freeze PC and pipeline registers
//   cause_out    0 none, 1 carry-ovf, 2 mul-ovf, 3 misaligned, 4 div0
//   epc_out      PC of the faulting instruction
//   badaddr_out  result_in captured at the fault
//   flags_out    {zero, negative, carry} of the last committed instruction
//   exc_count    number of exceptions taken
module alu_status_handler #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [7:0]        status_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        chk_mask,
  input  logic              exc_ack,
  output logic              exc_req,
  output logic              flush_out,
  output logic              stall_out,
  output logic [3:0]        cause_out,
  output logic [DATA_W-1:0] epc_out,
  output logic [DATA_W-1:0] badaddr_out,
  output logic [2:0]        flags_out,
  output logic [CNT_W-1:0]  exc_count
);

  typedef enum logic [1:0] {IDLE, TRAP, WAIT_ACK} state_t;

  localparam logic [3:0] CAUSE_CARRY = 4'd1;
  localparam logic [3:0] CAUSE_MUL   = 4'd2;
  localparam logic [3:0] CAUSE_ALIGN = 4'd3;
  localparam logic [3:0] CAUSE_DIV0  = 4'd4;

  state_t     state, state_nxt;
  logic [3:0] hit;        // {div0, align, mul, carry}
  logic [3:0] cause_sel;
  logic       accept;
  logic       take_trap;

  // Reserved status bits carry no meaning here.
  logic unused_status;
  assign unused_status = ^status_in[1:0];

  assign hit = {chk_mask[0] & status_in[2],
                chk_mask[1] & status_in[3],
                chk_mask[2] & status_in[6],
                chk_mask[3] & status_in[5]};

  // Instructions are only looked at in IDLE; TRAP/WAIT_ACK ignore EX entirely.
  assign accept    = valid_in && (state == IDLE);
  assign take_trap = accept && (hit != 4'b0000);

  always_comb begin
    cause_sel = 4'd0;
    if (hit[3])      cause_sel = CAUSE_DIV0;
    else if (hit[2]) cause_sel = CAUSE_ALIGN;
    else if (hit[1]) cause_sel = CAUSE_MUL;
    else if (hit[0]) cause_sel = CAUSE_CARRY;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take_trap) state_nxt = TRAP;
      TRAP:     state_nxt = WAIT_ACK;
      WAIT_ACK: if (exc_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are flops driven from the next state, so they rise in
  // the cycle after the fault is sampled and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_req   <= 1'b0;
      flush_out <= 1'b0;
      stall_out <= 1'b0;
    end else begin
      exc_req   <= (state_nxt != IDLE);
      flush_out <= (state_nxt == TRAP);
      stall_out <= (state_nxt != IDLE);
    end
  end

  // ---------------- exception record / flags ----------------
  // cause/epc/badaddr are sticky until the next trap overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_out   <= 4'd0;
      epc_out     <= '0;
      badaddr_out <= '0;
      flags_out   <= 3'b000;
    end else if (take_trap) begin
      cause_out   <= cause_sel;
      epc_out     <= pc_in;
      badaddr_out <= result_in;
    end else if (accept) begin
      flags_out   <= {status_in[7], status_in[4], status_in[5]};
    end
  end

  // ---------------- optional exception counter ----------------
`ifdef ALU_EXC_COUNTER_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (take_trap && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign exc_count = cnt;
`else
  assign exc_count = '0;
`endif

endmodule

// File: tb/tb_alu_status_handler.sv
module tb_alu_status_handler;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [7:0]    status_in;
  logic [DW-1:0] result_in;
  logic [DW-1:0] pc_in;
  logic [3:0]    chk_mask;
  logic          exc_ack;
  logic          exc_req, flush_out, stall_out;
  logic [3:0]    cause_out;
  logic [DW-1:0] epc_out, badaddr_out;
  logic [2:0]    flags_out;
  logic [CW-1:0] exc_count;

  alu_status_handler #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .status_in(status_in),
    .result_in(result_in), .pc_in(pc_in), .chk_mask(chk_mask),
    .exc_ack(exc_ack), .exc_req(exc_req), .flush_out(flush_out),
    .stall_out(stall_out), .cause_out(cause_out), .epc_out(epc_out),
    .badaddr_out(badaddr_out), .flags_out(flags_out), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req, flush, stall;
    logic [3:0]    cause;
    logic [DW-1:0] epc, bad;
    logic [2:0]    flags;
    int            cnt;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: trap age tells where we are in the handshake
  // (0 = no trap outstanding, 1 = first cycle after the fault, 2 = waiting).
  int            m_age;
  logic [3:0]    m_cause;
  logic [DW-1:0] m_epc, m_bad;
  logic [2:0]    m_flags;
  int            m_cnt;

  function automatic int cnt_max();
    return (1 << CW) - 1;
  endfunction

  task automatic model_reset();
    m_age = 0; m_cause = 0; m_epc = 0; m_bad = 0; m_flags = 0; m_cnt = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.req   = (m_age != 0);
    e.flush = (m_age == 1);
    e.stall = (m_age != 0);
    e.cause = m_cause;
    e.epc   = m_epc;
    e.bad   = m_bad;
    e.flags = m_flags;
`ifdef ALU_EXC_COUNTER_EN
    e.cnt = m_cnt;
`else
    e.cnt = 0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("exc_req",     exc_req,     e.req);
    chk("flush_out",   flush_out,   e.flush);
    chk("stall_out",   stall_out,   e.stall);
    chk("cause_out",   cause_out,   e.cause);
    chk("epc_out",     epc_out,     e.epc);
    chk("badaddr_out", badaddr_out, e.bad);
    chk("flags_out",   flags_out,   e.flags);
    chk("exc_count",   exc_count,   e.cnt);
  endtask

  // Monitor: DUT outputs are compared just after every active edge for which
  // the driver has posted an expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) compare(sb.pop_front());
  end

  // One clock of stimulus: drive at negedge, advance model at the posedge.
  task automatic step(input logic v, input logic [7:0] s, input logic [3:0] m,
                      input logic [DW-1:0] r, input logic [DW-1:0] p,
                      input logic ack);
    valid_in = v; status_in = s; chk_mask = m; result_in = r; pc_in = p;
    exc_ack = ack;
    @(posedge clk);
    if (m_age == 0) begin
      if (v) begin
        if (m[0] && s[2])      begin m_cause = 4; m_age = 1; end
        else if (m[1] && s[3]) begin m_cause = 3; m_age = 1; end
        else if (m[2] && s[6]) begin m_cause = 2; m_age = 1; end
        else if (m[3] && s[5]) begin m_cause = 1; m_age = 1; end
        if (m_age == 1) begin
          m_epc = p; m_bad = r;
          if (m_cnt < cnt_max()) m_cnt++;
        end else begin
          m_flags = {s[7], s[4], s[5]};
        end
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (ack) begin
      m_age = 0;
    end
    sb.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'h0, '0, '0, ack);
  endtask

  initial begin
    exp_t z;
    rst = 1'b1; valid_in = 0; status_in = 0; chk_mask = 0;
    result_in = 0; pc_in = 0; exc_ack = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare(model_out());                 // reset state
    rst = 1'b0;

    // carry trap, then acknowledge
    step(1, 8'h20, 4'b1000, 32'h0000_0abc, 32'h0000_0040, 0);
    idle(3, 0);
    step(0, 8'h00, 4'h0, '0, '0, 1);
    idle(1, 0);

    // priority: div0 beats mul/carry
    step(1, 8'h64, 4'b1111, 32'h0000_1002, 32'h0000_0080, 0);
    idle(2, 0);
    step(0, 8'h00, 4'h0, '0, '0, 1);

    // misaligned; valid on the ack cycle is dropped, next one updates flags
    step(1, 8'h08, 4'b0010, 32'h0000_2001, 32'h0000_00c0, 0);
    idle(3, 0);
    step(1, 8'h90, 4'b0000, '0, 32'h0000_00c4, 1);
    step(1, 8'h90, 4'b0000, '0, 32'h0000_00c8, 0);

    // masked faults and plain flag updates; ack in IDLE ignored
    step(1, 8'h90, 4'b0000, '0, 32'h100, 1);
    step(1, 8'h20, 4'b0000, '0, 32'h104, 0);
    step(1, 8'h7f, 4'b0000, '0, 32'h108, 0);
    step(1, 8'h03, 4'b1111, '0, 32'h10c, 0);   // reserved bits never trap

    // reset during WAIT_ACK
    step(1, 8'h04, 4'b0001, 32'h55, 32'h200, 0);
    idle(2, 0);
    rst = 1'b1;
    #1;
    model_reset();
    z = model_out();
    compare(z);
    @(negedge clk);
    rst = 1'b0;
    idle(3, 0);

    // five acknowledged traps: counter saturates
    for (int k = 0; k < 5; k++) begin
      step(1, 8'h40, 4'b0100, 32'h300 + k, 32'h400 + 4*k, 0);
      idle(2, 0);
      step(0, 8'h00, 4'h0, '0, '0, 1);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic       v, a;
      logic [3:0] m;
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      step(v, 8'($urandom), m, $urandom, $urandom, a);
    end
    idle(4, 1);

    @(posedge clk); #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_status_handler.md
Name: alu_status_handler

Overview:
- Consumes the 8-bit ALU status vector and result at the end of EX and turns selected flags into precise exceptions for the control unit.
- Registers branch flags (zero/negative/carry) for the next stage and latches cause, EPC and bad address.
- Drives a flush/stall handshake so the pipeline freezes until the exception controller acknowledges.

Parameters:
- DATA_W, 32, width of result_in, pc_in, epc_out, badaddr_out
- CNT_W, 8, width of the saturating exception counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  EX stage holds a valid instruction this cycle
- status_in  in  8  ALU status:
  - [7] zero, [6] mul overflow, [5] add/sub carry, [4] negative
  - [3] address-check flag, [2] divide-by-zero, [1:0] reserved 0
- result_in  in  DATA_W  ALU result (effective address for loads/stores)
- pc_in  in  DATA_W  PC of the EX instruction
- chk_mask  in  4  per-instruction enables: [3] carry-ovf, [2] mul-ovf, [1] align, [0] div0
- exc_ack  in  1  exception controller has taken the trap
- exc_req  out  1  exception pending
- flush_out  out  1  one-cycle pulse: kill IF/ID/EX
- stall_out  out  1  freeze PC and pipeline registers
- cause_out  out  4  0 none, 1 carry-ovf, 2 mul-ovf, 3 misaligned, 4 div0
- epc_out  out  DATA_W  PC of faulting instruction
- badaddr_out  out  DATA_W  result_in at the fault (valid for cause 3)
- flags_out  out  3  {zero, negative, carry} of last committed instruction
- exc_count  out  CNT_W  number of exceptions taken (see optional feature)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Hit vector: {chk_mask[0]&status[2], chk_mask[1]&status[3], chk_mask[2]&status[6], chk_mask[3]&status[5]}.
- Priority: div0 > misaligned > mul-ovf > carry-ovf. Exactly one cause is latched.
- FSM states:
  - IDLE
    - valid_in=1 and hit=0: flags_out <= {status[7], status[4], status[5]}. No other change.
    - valid_in=1 and hit!=0: latch cause_out, epc_out <= pc_in, badaddr_out <= result_in. flags_out unchanged. Go to TRAP.
    - valid_in=0: all outputs hold.
  - TRAP (exactly 1 cycle): flush_out=1, exc_req=1, stall_out=1. exc_ack is ignored. Go to WAIT_ACK.
  - WAIT_ACK: exc_req=1, stall_out=1, flush_out=0.
    - exc_ack=1: go to IDLE; exc_req and stall_out are 0 from the next cycle.
    - cause_out, epc_out and badaddr_out stay sticky until the next exception overwrites them.
- Latency: the fault is sampled in cycle N. exc_req, flush_out and stall_out are registered and first high in cycle N+1.
- In TRAP and WAIT_ACK, valid_in and status_in are ignored. No flag update and no second trap.
- exc_ack and valid_in in the same WAIT_ACK cycle: valid_in is dropped. The first instruction is accepted in IDLE, one cycle later.
- exc_ack while in IDLE: ignored.
- Reserved status bits [1:0] are ignored. chk_mask=0 never traps.
- Reset asserted mid-trap: immediate return to IDLE with all outputs 0, no flush pulse.

Optional Feature:
- Macro: ALU_EXC_COUNTER_EN
- Defined:
  - exc_count increments by 1 on each IDLE->TRAP transition.
  - It saturates at 2^CNT_W-1 and clears only on rst.
- Undefined: exc_count is tied to 0 and no counter flops are built.

Test Plan:
- Carry trap: rst released. valid_in=1, status_in=8'h20, chk_mask=4'b1000, pc_in=32'h0000_0040.
  - Next cycle: exc_req=1, flush_out=1, cause_out=1, epc_out=32'h40.
  - Following cycle: flush_out=0, exc_req=1.
- Priority: status_in=8'h64, chk_mask=4'b1111, result_in=32'h1002.
  - cause_out=4 (div0 wins); badaddr_out=32'h1002.
- Misaligned: status_in=8'h08, chk_mask=4'b0010.
  - cause_out=3.
  - exc_ack held 3 cycles later: exc_req=0 and stall_out=0 the cycle after ack.
  - valid_in presented on the ack cycle is dropped; valid_in one cycle later updates flags_out.
- No trap / masked fault: status_in=8'h90, chk_mask=4'b0000.
  - exc_req stays 0; flags_out=3'b110.
  - Then status_in=8'h20 with chk_mask=0: flags_out=3'b001, no trap.
- Reset mid-trap: fault, then rst pulsed during WAIT_ACK.
  - All outputs 0 immediately (asynchronous); FSM in IDLE; no flush_out after release.
- Counter (macro defined, CNT_W=2): 5 traps, each acknowledged.
  - exc_count sequence 1, 2, 3, 3, 3.
  - With macro undefined: exc_count=0 throughout.
